// File: rtl/nabp_pe_accumulator.sv
// Back-projection processing element: accumulates filtered taps into a local
// pixel buffer across projection angles and drains it over a valid/ready stream.
module nabp_pe_accumulator #(
    parameter int pDataLength = 16,
    parameter int pAccuLength = 24,
    parameter int pBufDepth   = 16,
    parameter int pPtrLength  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sc_clear_kick,
    input  logic                          sc_dump_kick,
    input  logic                          pe_en,
    input  logic signed [pDataLength-1:0] pe_tap,
    input  logic                          itr_done,
    input  logic                          out_ready,
    output logic signed [pAccuLength-1:0] out_val,
    output logic                          out_valid,
    output logic                          out_last,
    output logic                          busy,
    output logic                          ovf
);

    typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DUMP} state_t;
    typedef enum logic [1:0] {KICK_NONE, KICK_CLEAR, KICK_DUMP} kick_t;

    localparam logic [pPtrLength-1:0] LAST_PTR = pPtrLength'(pBufDepth - 1);

    state_t state, state_d;
    kick_t  kick_pend, kick_pend_d;
    logic [pPtrLength-1:0] ptr, ptr_d;
    logic acc_en;
    logic ovf_clr;

    logic signed [pAccuLength-1:0] buf_mem [pBufDepth];
    logic signed [pAccuLength-1:0] acc_op_p0;
    logic signed [pAccuLength:0]   acc_ext_p0;
    logic signed [pAccuLength:0]   tap_ext_p0;
    logic signed [pAccuLength:0]   sum_wide_p0;

    logic                          wr_vld_p1;
    logic [pPtrLength-1:0]         wr_addr_p1;
    logic signed [pAccuLength-1:0] wr_sum_p1;

    function automatic logic [pPtrLength-1:0] ptr_inc(input logic [pPtrLength-1:0] p);
        return (p == LAST_PTR) ? '0 : p + pPtrLength'(1);
    endfunction

    function automatic logic is_clamped(input logic signed [pAccuLength:0] s);
        return s[pAccuLength] != s[pAccuLength-1];
    endfunction

    function automatic logic signed [pAccuLength-1:0] sat_acc(input logic signed [pAccuLength:0] s);
        if (!is_clamped(s))
            return s[pAccuLength-1:0];
        else if (s[pAccuLength])
            return {1'b1, {(pAccuLength-1){1'b0}}};
        else
            return {1'b0, {(pAccuLength-1){1'b1}}};
    endfunction

    // Stage p0: read (with forwarding of the in-flight write) and add
    always_comb begin
        if (wr_vld_p1 && (wr_addr_p1 == ptr))
            acc_op_p0 = wr_sum_p1;
        else
            acc_op_p0 = buf_mem[ptr];
        acc_ext_p0  = {acc_op_p0[pAccuLength-1], acc_op_p0};
        tap_ext_p0  = {{(pAccuLength+1-pDataLength){pe_tap[pDataLength-1]}}, pe_tap};
        sum_wide_p0 = acc_ext_p0 + tap_ext_p0;
    end

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        kick_pend_d = kick_pend;
        acc_en      = 1'b0;
        ovf_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (sc_clear_kick) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else if (sc_dump_kick) begin
                    state_d = DUMP;
                    ptr_d   = '0;
                end else if (pe_en) begin
                    acc_en  = 1'b1;
                    state_d = ACCUM;
                    ptr_d   = itr_done ? '0 : ptr_inc(ptr);
                end else if (itr_done) begin
                    ptr_d = '0;
                end
            end
            ACCUM: begin
                // A kick that arrived with pe_en leaves after the write has retired
                if (kick_pend != KICK_NONE) begin
                    state_d     = (kick_pend == KICK_CLEAR) ? CLEAR : DUMP;
                    ptr_d       = '0;
                    kick_pend_d = KICK_NONE;
                end else if (pe_en) begin
                    acc_en = 1'b1;
                    ptr_d  = itr_done ? '0 : ptr_inc(ptr);
                    if (sc_clear_kick)
                        kick_pend_d = KICK_CLEAR;
                    else if (sc_dump_kick)
                        kick_pend_d = KICK_DUMP;
                end else if (sc_clear_kick) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else if (sc_dump_kick) begin
                    state_d = DUMP;
                    ptr_d   = '0;
                end else if (itr_done) begin
                    ptr_d = '0;
                end
            end
            CLEAR: begin
                if (ptr == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    ovf_clr = 1'b1;
                end else begin
                    ptr_d = ptr + pPtrLength'(1);
                end
            end
            DUMP: begin
                if (out_ready) begin
                    if (ptr == LAST_PTR) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr + pPtrLength'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            kick_pend <= KICK_NONE;
            ptr       <= '0;
            wr_vld_p1 <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_d;
            kick_pend <= kick_pend_d;
            ptr       <= ptr_d;
            wr_vld_p1 <= acc_en;
            if (ovf_clr)
                ovf <= 1'b0;
            else if (acc_en && is_clamped(sum_wide_p0))
                ovf <= 1'b1;
        end
    end

    // Stage p1: registered saturated sum, written back one cycle after the read
    always_ff @(posedge clk) begin
        if (acc_en) begin
            wr_addr_p1 <= ptr;
            wr_sum_p1  <= sat_acc(sum_wide_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld_p1)
            buf_mem[wr_addr_p1] <= wr_sum_p1;
        else if (state == CLEAR)
            buf_mem[ptr] <= '0;
    end

    assign out_valid = (state == DUMP);
    assign out_last  = (state == DUMP) && (ptr == LAST_PTR);
    assign out_val   = (state == DUMP) ? buf_mem[ptr] : '0;
    assign busy      = (state == CLEAR) || (state == DUMP);

endmodule

// File: tb/tb_nabp_pe_accumulator.sv
// Directed bench for nabp_pe_accumulator: a 24-bit and an 18-bit accumulator
// instance share one stimulus stream.
module tb_nabp_pe_accumulator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sc_clear_kick = 1'b0;
    logic sc_dump_kick = 1'b0;
    logic pe_en = 1'b0;
    logic signed [15:0] pe_tap = '0;
    logic itr_done = 1'b0;
    logic out_ready = 1'b0;

    logic signed [23:0] out_val;
    logic out_valid, out_last, busy, ovf;
    logic signed [17:0] out_val_n;
    logic out_valid_n, out_last_n, busy_n, ovf_n;

    int checks = 0;
    int failures = 0;

    logic signed [23:0] exp24 [16];
    logic signed [17:0] exp18 [16];

    always #5 clk = ~clk;

    nabp_pe_accumulator #(
        .pDataLength(16), .pAccuLength(24), .pBufDepth(16), .pPtrLength(4)
    ) dut (
        .clk(clk), .reset(reset), .sc_clear_kick(sc_clear_kick), .sc_dump_kick(sc_dump_kick),
        .pe_en(pe_en), .pe_tap(pe_tap), .itr_done(itr_done), .out_ready(out_ready),
        .out_val(out_val), .out_valid(out_valid), .out_last(out_last), .busy(busy), .ovf(ovf)
    );

    nabp_pe_accumulator #(
        .pDataLength(16), .pAccuLength(18), .pBufDepth(16), .pPtrLength(4)
    ) dut_n (
        .clk(clk), .reset(reset), .sc_clear_kick(sc_clear_kick), .sc_dump_kick(sc_dump_kick),
        .pe_en(pe_en), .pe_tap(pe_tap), .itr_done(itr_done), .out_ready(out_ready),
        .out_val(out_val_n), .out_valid(out_valid_n), .out_last(out_last_n), .busy(busy_n), .ovf(ovf_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_clear(input string tag);
        int cnt;
        cnt = 0;
        sc_clear_kick = 1'b1;
        step();
        sc_clear_kick = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!busy) break;
            cnt++;
            step();
        end
        chk_val({tag, "_busy_cycles"}, 64'(cnt), 64'(16));
        chk_bit({tag, "_busy_n"}, busy_n, 1'b0);
    endtask

    task automatic dump_all(input string tag);
        out_ready = 1'b1;
        sc_dump_kick = 1'b1;
        step();
        sc_dump_kick = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_bit($sformatf("%s_valid%0d", tag, k), out_valid, 1'b1);
            chk_val($sformatf("%s_val%0d", tag, k), 64'(out_val), 64'(exp24[k]));
            chk_val($sformatf("%s_val_n%0d", tag, k), 64'(out_val_n), 64'(exp18[k]));
            chk_bit($sformatf("%s_last%0d", tag, k), out_last, k == 15);
            step();
        end
        chk_bit({tag, "_busy_after"}, busy, 1'b0);
        chk_bit({tag, "_valid_after"}, out_valid, 1'b0);
    endtask

    task automatic set_exp_ramp3();
        for (int k = 0; k < 16; k++) begin
            exp24[k] = 24'(3 * (k + 1));
            exp18[k] = 18'(3 * (k + 1));
        end
    endtask

    task automatic set_exp_zero();
        for (int k = 0; k < 16; k++) begin
            exp24[k] = '0;
            exp18[k] = '0;
        end
    endtask

    initial begin
        int idx;

        // Reset state
        #2;
        chk_bit("rst_valid", out_valid, 1'b0);
        chk_bit("rst_last", out_last, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_ovf", ovf, 1'b0);
        chk_val("rst_val", 64'(out_val), 64'(0));
        step();
        reset = 1'b0;
        step();

        // Clear takes 16 busy cycles, then an all-zero dump
        do_clear("clr1");
        set_exp_zero();
        dump_all("dump_zero");

        // Three angles of taps 1..16
        do_clear("clr2");
        for (int a = 0; a < 3; a++) begin
            for (int k = 0; k < 16; k++) begin
                pe_en = 1'b1;
                pe_tap = 16'(k + 1);
                itr_done = (k == 15);
                step();
            end
        end
        pe_en = 1'b0;
        itr_done = 1'b0;
        pe_tap = '0;
        set_exp_ramp3();
        dump_all("dump_ramp");

        // Stalled dump, ready pattern 1,0,0 repeating; contents preserved
        idx = 0;
        out_ready = 1'b0;
        sc_dump_kick = 1'b1;
        step();
        sc_dump_kick = 1'b0;
        for (int c = 0; c < 60 && idx < 16; c++) begin
            out_ready = (c % 3 == 0);
            chk_bit($sformatf("stall_valid_c%0d", c), out_valid, 1'b1);
            chk_val($sformatf("stall_val_c%0d", c), 64'(out_val), 64'(exp24[idx]));
            chk_bit($sformatf("stall_last_c%0d", c), out_last, idx == 15);
            if (out_ready) idx++;
            step();
        end
        out_ready = 1'b1;
        chk_val("stall_words", 64'(idx), 64'(16));
        chk_bit("stall_busy_after", busy, 1'b0);

        // Reset at word 6 of a dump, then dump again from word 0
        sc_dump_kick = 1'b1;
        step();
        sc_dump_kick = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk_val("mid_word6", 64'(out_val), 64'(exp24[6]));
        #2 reset = 1'b1;
        #1;
        chk_bit("mid_rst_valid", out_valid, 1'b0);
        chk_bit("mid_rst_busy", busy, 1'b0);
        chk_bit("mid_rst_last", out_last, 1'b0);
        chk_val("mid_rst_val", 64'(out_val), 64'(0));
        #2 reset = 1'b0;
        step();
        dump_all("dump_after_rst");

        // Forwarding: tap 5 with itr_done, then tap 7 re-hits entry 0
        do_clear("clr3");
        pe_en = 1'b1;
        pe_tap = 16'sd5;
        itr_done = 1'b1;
        step();
        pe_tap = 16'sd7;
        itr_done = 1'b0;
        step();
        pe_en = 1'b0;
        pe_tap = '0;
        set_exp_zero();
        exp24[0] = 24'sd12;
        exp18[0] = 18'sd12;
        dump_all("dump_fwd");

        // Positive saturation of the 18-bit instance
        do_clear("clr4");
        pe_tap = 16'sd32767;
        itr_done = 1'b1;
        pe_en = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk_bit("pos_ovf_n_before", ovf_n, 1'b0);
        step();
        pe_en = 1'b0;
        itr_done = 1'b0;
        pe_tap = '0;
        chk_bit("pos_ovf_n", ovf_n, 1'b1);
        chk_bit("pos_ovf_wide", ovf, 1'b0);
        set_exp_zero();
        exp24[0] = 24'sd163835;
        exp18[0] = 18'sd131071;
        dump_all("dump_pos_sat");
        chk_bit("pos_ovf_sticky", ovf_n, 1'b1);
        do_clear("clr5");
        chk_bit("pos_ovf_cleared", ovf_n, 1'b0);

        // Negative saturation: four adds land exactly on the minimum
        pe_tap = -16'sd32768;
        itr_done = 1'b1;
        pe_en = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk_bit("neg_ovf_n_before", ovf_n, 1'b0);
        step();
        pe_en = 1'b0;
        itr_done = 1'b0;
        pe_tap = '0;
        chk_bit("neg_ovf_n", ovf_n, 1'b1);
        set_exp_zero();
        exp24[0] = -24'sd163840;
        exp18[0] = -18'sd131072;
        dump_all("dump_neg_sat");
        do_clear("clr6");
        chk_bit("neg_ovf_cleared", ovf_n, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
